// File: rtl/mipi_tx_payload_read_ctrl_if.sv
// Handshake bundle between the MIPI TX core, the pixel FIFO and the payload read controller.
// The master side is the TX core / FIFO environment; the slave side is the read controller.
interface mipi_tx_payload_read_ctrl_if #(
  parameter int unsigned DATA_BYTES = 4
);
  logic                  Tx_cmd_req;
  logic [5:0]            Tx_cmd_data_type;
  logic [1:0]            Tx_cmd_vc;
  logic [15:0]           Tx_cmd_wc;
  logic                  Tx_cmd_ack;
  logic                  Tx_payload_en;
  logic                  Tx_payload_en_last;
  logic                  Fifo_empty;
  logic                  Err_clr;
  logic                  Fifo_readen;
  logic [DATA_BYTES-1:0] Byte_valid;
  logic                  Busy;
  logic                  Err_underflow;
  logic                  Err_length;

  modport master (
    output Tx_cmd_req, Tx_cmd_data_type, Tx_cmd_vc, Tx_cmd_wc, Tx_cmd_ack,
           Tx_payload_en, Tx_payload_en_last, Fifo_empty, Err_clr,
    input  Fifo_readen, Byte_valid, Busy, Err_underflow, Err_length
  );

  modport slave (
    input  Tx_cmd_req, Tx_cmd_data_type, Tx_cmd_vc, Tx_cmd_wc, Tx_cmd_ack,
           Tx_payload_en, Tx_payload_en_last, Fifo_empty, Err_clr,
    output Fifo_readen, Byte_valid, Busy, Err_underflow, Err_length
  );
endinterface

// File: rtl/mipi_tx_payload_read_ctrl.sv
// Pixel FIFO read-enable generator for the MIPI TX long-packet path: filters requests by
// data type / VC, tracks the word count per beat and flags underflow / length errors.
module mipi_tx_payload_read_ctrl #(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [5:0]  DT0        = 6'h3E,
  parameter logic [5:0]  DT1        = 6'h24,
  parameter logic [5:0]  DT2        = 6'h2B,
  parameter logic [5:0]  DT3        = 6'h2C,
  parameter logic [3:0]  DT_EN      = 4'b0001,
  parameter logic [3:0]  VC_EN      = 4'b1111
) (
  input logic                     CLK_tx,
  input logic                     RSTn,
  mipi_tx_payload_read_ctrl_if.slave io_tx
);

  typedef enum logic [1:0] {StIdle, StReq, StPayload} state_e;

  localparam logic [15:0] BeatBytes = 16'(DATA_BYTES);

  state_e                r_state, w_state_nxt;
  logic [15:0]           r_pend_wc, w_pend_wc_nxt;
  logic [15:0]           r_remaining, w_remaining_nxt;
  logic                  r_err_underflow, w_err_underflow_nxt;
  logic                  r_err_length, w_err_length_nxt;
  logic                  w_dt_hit, w_match, w_accept;
  logic                  w_beat, w_overrun, w_underrun;
  logic [DATA_BYTES-1:0] w_byte_valid;

  always_comb begin
    w_dt_hit = (DT_EN[0] && (io_tx.Tx_cmd_data_type == DT0)) ||
               (DT_EN[1] && (io_tx.Tx_cmd_data_type == DT1)) ||
               (DT_EN[2] && (io_tx.Tx_cmd_data_type == DT2)) ||
               (DT_EN[3] && (io_tx.Tx_cmd_data_type == DT3));
    w_match  = w_dt_hit && VC_EN[io_tx.Tx_cmd_vc];
    w_accept = io_tx.Tx_cmd_req && w_match && (io_tx.Tx_cmd_wc != 16'd0);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_wc_nxt   = r_pend_wc;
    w_remaining_nxt = r_remaining;
    w_beat          = 1'b0;
    w_overrun       = 1'b0;
    w_underrun      = 1'b0;
    w_byte_valid    = '0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_pend_wc_nxt = io_tx.Tx_cmd_wc;
          w_state_nxt   = StReq;
        end
      end
      StReq: begin
        // Ack takes priority over a simultaneous re-request and uses the held word count.
        if (io_tx.Tx_cmd_ack) begin
          w_remaining_nxt = r_pend_wc;
          w_state_nxt     = StPayload;
        end else if (io_tx.Tx_cmd_req) begin
          if (w_accept) w_pend_wc_nxt = io_tx.Tx_cmd_wc;
          else          w_state_nxt   = StIdle;
        end
      end
      StPayload: begin
        if (io_tx.Tx_payload_en) begin
          w_beat = 1'b1;
          for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            w_byte_valid[i] = (r_remaining > 16'(i));
          end
          w_remaining_nxt = (r_remaining >= BeatBytes) ? (r_remaining - BeatBytes) : 16'd0;
          w_overrun       = (r_remaining == 16'd0);
          w_underrun      = io_tx.Tx_payload_en_last && (w_remaining_nxt != 16'd0);
          if (io_tx.Tx_payload_en_last) w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Setting an error wins over a simultaneous clear.
    w_err_underflow_nxt = (w_beat && io_tx.Fifo_empty) ||
                          (r_err_underflow && !io_tx.Err_clr);
    w_err_length_nxt    = w_overrun || w_underrun || (r_err_length && !io_tx.Err_clr);
  end

  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      r_state         <= StIdle;
      r_pend_wc       <= 16'd0;
      r_remaining     <= 16'd0;
      r_err_underflow <= 1'b0;
      r_err_length    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pend_wc       <= w_pend_wc_nxt;
      r_remaining     <= w_remaining_nxt;
      r_err_underflow <= w_err_underflow_nxt;
      r_err_length    <= w_err_length_nxt;
    end
  end

  assign io_tx.Fifo_readen   = w_beat;
  assign io_tx.Byte_valid    = w_byte_valid;
  assign io_tx.Busy          = (r_state != StIdle);
  assign io_tx.Err_underflow = r_err_underflow;
  assign io_tx.Err_length    = r_err_length;

endmodule

// File: doc/mipi_tx_payload_read_ctrl.md
Name: mipi_tx_payload_read_ctrl

Overview:
- Generalised FIFO read-enable generator for the MIPI CSI-2/DSI TX long-packet path. Sits between the TX command/payload handshake of the MIPI TX core and the video pixel FIFO.
- Supports up to four configurable payload data types and per-virtual-channel gating.
- Tracks the word count to produce per-beat byte valids on the final beat.
- Flags FIFO underflow and payload-length mismatch as sticky errors.

Parameters:
- DATA_BYTES, 4, bytes per payload beat; legal values 1, 2, 4, 8.
- DT0, 6'h3E, payload data type code slot 0 (RGB888).
- DT1, 6'h24, payload data type code slot 1 (RGB888 CSI).
- DT2, 6'h2B, payload data type code slot 2 (RAW10).
- DT3, 6'h2C, payload data type code slot 3 (RAW12).
- DT_EN, 4'b0001, per-slot enable; bit n enables DTn.
- VC_EN, 4'b1111, per-virtual-channel enable; bit n enables VC n.

Ports:
- CLK_tx  in  1  TX byte clock.
- RSTn  in  1  asynchronous active-low reset.
- Tx_cmd_req  in  1  packet request strobe from the packet scheduler.
- Tx_cmd_data_type  in  6  data type of the requested packet.
- Tx_cmd_vc  in  2  virtual channel of the requested packet.
- Tx_cmd_wc  in  16  word count of the requested packet, in bytes.
- Tx_cmd_ack  in  1  TX core accepts the pending request.
- Tx_payload_en  in  1  TX core consumes one payload beat this cycle.
- Tx_payload_en_last  in  1  qualifies the final payload beat.
- Fifo_empty  in  1  pixel FIFO empty.
- Err_clr  in  1  clears the sticky error flags.
- Fifo_readen  out  1  FIFO read strobe.
- Byte_valid  out  DATA_BYTES  valid bytes of the current beat, LSB = first byte.
- Busy  out  1  a request is pending or a payload is in progress.
- Err_underflow  out  1  sticky: a FIFO read was issued while the FIFO was empty.
- Err_length  out  1  sticky: the beat count disagreed with the word count.

Behaviour:
- Reset (async, RSTn=0) forces: state IDLE, remaining=0, Err_underflow=0, Err_length=0, latched type/VC/WC cleared. Hence Fifo_readen=0, Byte_valid=0, Busy=0.
- Match condition: match = (Tx_cmd_data_type == DTn with DT_EN[n] for some n) AND VC_EN[Tx_cmd_vc].
- FSM states: IDLE, REQ, PAYLOAD.
- IDLE:
  - On Tx_cmd_req with match and Tx_cmd_wc != 0: latch wc into pend_wc, go to REQ.
  - On Tx_cmd_req that does not match, or has wc = 0: stay IDLE.
  - Tx_cmd_ack is ignored.
- REQ:
  - On Tx_cmd_ack: remaining <= pend_wc, go to PAYLOAD.
  - On a new Tx_cmd_req without ack: re-evaluate the request. If it matches, relatch and stay in REQ; otherwise return to IDLE.
  - If req and ack occur in the same cycle, ack wins and uses the previously latched wc.
- PAYLOAD:
  - Fifo_readen = Tx_payload_en. This output is combinational, with zero latency from Tx_payload_en.
  - Tx_cmd_req is ignored in this state.
  - Per beat with Tx_payload_en:
    - If remaining >= DATA_BYTES: Byte_valid = all ones and remaining -= DATA_BYTES.
    - Otherwise: Byte_valid = (1<<remaining)-1 and remaining becomes 0.
  - Byte_valid = 0 when Tx_payload_en = 0.
  - On a beat with Tx_payload_en_last: go to IDLE.
- Busy = (state != IDLE).
- Err_length is set when either:
  - a beat occurs while remaining = 0 (overrun; Fifo_readen still asserts and Byte_valid = 0), or
  - a last beat leaves remaining != 0 after the beat (underrun).
- Err_underflow is set on Fifo_readen & Fifo_empty. The read is still issued; the block does not stall.
- Err_clr clears both error flags. If an error is set in the same cycle as Err_clr, set wins.
- Tx_payload_en_last outside PAYLOAD is ignored, and Tx_payload_en outside PAYLOAD gives Fifo_readen = 0.
- Remaining counter is 16 bit and saturates at 0; it never wraps.
- Async reset during PAYLOAD takes effect immediately: Fifo_readen drops in the same cycle and the packet is abandoned.

Test Plan:
- DT 6'h3E, VC 0, wc=12, DATA_BYTES=4; req, ack, then 3 beats with last on beat 3 -> Fifo_readen high for exactly 3 cycles, Byte_valid 4'hF each beat, no errors, Busy drops after beat 3.
- DT 6'h3E, wc=10 -> 3 beats with Byte_valid F, F, 3; last on beat 3 -> Err_length stays 0.
- Short packet DT 6'h01, plus DT 6'h24 with DT_EN=4'b0001, plus DT 6'h3E on VC 2 with VC_EN=4'b1011; each followed by ack and 4 payload_en pulses -> Fifo_readen never asserts and Busy stays 0.
- wc=8 with last asserted on beat 1 -> Err_length=1 after the beat. Then wc=4 with 2 beats and last on beat 2 -> Err_length set, and beat 2 gives Fifo_readen=1 with Byte_valid=0.
- Fifo_empty=1 during beat 2 of a 3-beat packet -> Err_underflow=1 and stays set. Pulse Err_clr together with a new underflow -> flag stays 1. Pulse Err_clr alone -> flag returns to 0.
- Assert RSTn=0 mid-PAYLOAD with Tx_payload_en=1 -> Fifo_readen goes to 0 immediately. After release, state is IDLE; the next payload_en without a req/ack gives no readen.
